// File: rtl/mac_setup_pkg.sv
// Shared constants, FSM state codes and setup-frame byte addressing for the
// DELQA receive-address filter loader.
package mac_setup_pkg;

    localparam int NUM_ENTRIES = 14;
    localparam int COLS        = 7;
    localparam int HALF_OFS    = 64;

    localparam logic [2:0] REG_IDX = 3'd0;
    localparam logic [2:0] REG_W1  = 3'd1;
    localparam logic [2:0] REG_W2  = 3'd2;
    localparam logic [2:0] REG_W3  = 3'd3;

    typedef logic [3:0] state_t;
    localparam state_t ST_IDLE    = 4'd0;
    localparam state_t ST_ENTER   = 4'd1;
    localparam state_t ST_FETCH   = 4'd2;
    localparam state_t ST_WR_IDX  = 4'd3;
    localparam state_t ST_WR_W1   = 4'd4;
    localparam state_t ST_WR_W2   = 4'd5;
    localparam state_t ST_WR_W3   = 4'd6;
    localparam state_t ST_VERIFY  = 4'd7;
    localparam state_t ST_NEXT    = 4'd8;
    localparam state_t ST_WR_ZERO = 4'd9;
    localparam state_t ST_EXIT    = 4'd10;

    // DELQA setup frame: two 64-byte halves, 7 address columns, byte k of an
    // address lives in row k (8-byte stride), column 0 starts at offset 1.
    function automatic logic [7:0] byte_ofs(input logic [3:0] e, input logic [2:0] k);
        logic [7:0] base;
        logic [7:0] col;
        if (e < 4'(COLS)) begin
            base = 8'd0;
            col  = {4'd0, e};
        end else begin
            base = 8'(HALF_OFS);
            col  = {4'd0, e} - 8'(COLS);
        end
        return base + {2'b00, k, 3'b000} + col + 8'd1;
    endfunction

endpackage

// File: rtl/mac_setup_if.sv
// Wishbone master port toward the address-filter register block.
interface mac_setup_if;
    logic [2:0]  m_adr_o;
    logic [15:0] m_dat_o;
    logic [15:0] m_dat_i;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_we_o;
    logic [1:0]  m_sel_o;
    logic        m_ack_i;

    modport master (
        output m_adr_o, m_dat_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o,
        input  m_dat_i, m_ack_i
    );
    modport slave (
        input  m_adr_o, m_dat_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o,
        output m_dat_i, m_ack_i
    );
endinterface

// File: rtl/mac_wb_xfer.sv
// Single Wishbone transfer engine: one request -> one bus cycle, ending in a
// done pulse on ack or a tmo pulse after ACK_TMO cycles without ack.
module mac_wb_xfer #(
    parameter int ACK_TMO = 16
) (
    input  logic        wb_clk_i,
    input  logic        rst_i,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  adr,
    input  logic [15:0] dat,
    output logic [15:0] rdat,
    output logic        done,
    output logic        tmo,
    mac_setup_if.master bus
);

    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [2:0]  adr_q, adr_d;
    logic [15:0] dat_q, dat_d;
    logic [15:0] rdat_q, rdat_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        tmo_q, tmo_d;

    always_comb begin
        cyc_d  = cyc_q;
        we_d   = we_q;
        adr_d  = adr_q;
        dat_d  = dat_q;
        rdat_d = rdat_q;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        tmo_d  = 1'b0;
        if (!cyc_q) begin
            if (req) begin
                cyc_d = 1'b1;
                we_d  = we;
                adr_d = adr;
                dat_d = dat;
                cnt_d = 8'd0;
            end
        end else if (bus.m_ack_i) begin
            // ack is registered here; cyc/stb fall on the following cycle
            cyc_d  = 1'b0;
            done_d = 1'b1;
            rdat_d = bus.m_dat_i;
        end else if (cnt_q == 8'(ACK_TMO - 1)) begin
            cyc_d = 1'b0;
            tmo_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_q  <= 1'b0;
            we_q   <= 1'b0;
            adr_q  <= 3'd0;
            dat_q  <= 16'd0;
            rdat_q <= 16'd0;
            cnt_q  <= 8'd0;
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            cyc_q  <= cyc_d;
            we_q   <= we_d;
            adr_q  <= adr_d;
            dat_q  <= dat_d;
            rdat_q <= rdat_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            tmo_q  <= tmo_d;
        end
    end

    assign bus.m_cyc_o = cyc_q;
    assign bus.m_stb_o = cyc_q;
    assign bus.m_we_o  = cyc_q & we_q;
    assign bus.m_adr_o = adr_q;
    assign bus.m_dat_o = dat_q;
    assign bus.m_sel_o = 2'b11;
    assign rdat        = rdat_q;
    assign done        = done_q;
    assign tmo         = tmo_q;

endmodule

// File: rtl/mac_setup_seq.sv
// Loads the 14-entry receive address filter from a DELQA setup frame.
// Optional readback check of every entry: define MAC_SETUP_VERIFY_EN.
module mac_setup_seq
    import mac_setup_pkg::*;
#(
    parameter int ACK_TMO = 16,
    parameter int SETTLE  = 2
) (
    input  logic        wb_clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  len_i,
    input  logic        promisc_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [6:0]  buf_adr_o,
    input  logic [7:0]  buf_dat_i,
    mac_setup_if.master m,
    output logic [1:0]  pms_o
);

    state_t          state_q, state_d;
    logic [3:0]      e_q, e_d;
    logic [2:0]      k_q, k_d;
    logic [7:0]      s_q, s_d;
    logic [7:0]      len_q, len_d;
    logic [5:0][7:0] byte_q, byte_d;
    logic            oob_q, oob_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            stpac_q, stpac_d;
    logic            pend_q, pend_d;

    logic        x_req, x_we, x_done, x_tmo, is_bus;
    logic [2:0]  x_adr;
    logic [15:0] x_dat, x_rdat, w1, w2, w3;
    logic [7:0]  ofs;

    assign w1 = {byte_q[1], byte_q[0]};
    assign w2 = {byte_q[3], byte_q[2]};
    assign w3 = {byte_q[5], byte_q[4]};

`ifdef MAC_SETUP_VERIFY_EN
    logic [1:0]  v_q, v_d;
    logic [15:0] exp_w;
    assign exp_w = (v_q == 2'd0) ? w1 : (v_q == 2'd1) ? w2 : w3;
`else
    logic unused_rdat;
    assign unused_rdat = ^x_rdat;
`endif

    mac_wb_xfer #(.ACK_TMO(ACK_TMO)) u_xfer (
        .wb_clk_i (wb_clk_i),
        .rst_i    (rst_i),
        .req      (x_req),
        .we       (x_we),
        .adr      (x_adr),
        .dat      (x_dat),
        .rdat     (x_rdat),
        .done     (x_done),
        .tmo      (x_tmo),
        .bus      (m)
    );

    assign is_bus = state_q inside {ST_WR_IDX, ST_WR_W1, ST_WR_W2, ST_WR_W3,
                                    ST_VERIFY, ST_WR_ZERO};
    // one request per bus state; pend blocks re-issue until done/tmo
    assign x_req  = is_bus && !pend_q;
    assign pend_d = x_req ? 1'b1 : ((x_done || x_tmo) ? 1'b0 : pend_q);
    assign ofs    = byte_ofs(e_q, k_q);

    always_comb begin
        x_we  = 1'b1;
        x_adr = REG_IDX;
        x_dat = 16'd0;
        case (state_q)
            ST_WR_IDX: x_dat = {12'd0, e_q};
            ST_WR_W1:  begin x_adr = REG_W1; x_dat = w1; end
            ST_WR_W2:  begin x_adr = REG_W2; x_dat = w2; end
            ST_WR_W3:  begin x_adr = REG_W3; x_dat = w3; end
`ifdef MAC_SETUP_VERIFY_EN
            ST_VERIFY: begin x_adr = REG_W1 + {1'b0, v_q}; x_we = 1'b0; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        e_d       = e_q;
        k_d       = k_q;
        s_d       = s_q;
        len_d     = len_q;
        byte_d    = byte_q;
        oob_d     = oob_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        stpac_d   = stpac_q;
        buf_adr_o = 7'd0;
`ifdef MAC_SETUP_VERIFY_EN
        v_d       = v_q;
`endif
        case (state_q)
            ST_IDLE: if (start_i && !done_q) begin
                len_d   = (len_i > 8'd128) ? 8'd128 : len_i;
                err_d   = 1'b0;
                busy_d  = 1'b1;
                stpac_d = 1'b1;
                s_d     = 8'd0;
                state_d = ST_ENTER;
            end
            ST_ENTER: if (s_q == 8'(SETTLE - 1)) begin
                e_d     = 4'd0;
                k_d     = 3'd0;
                state_d = ST_FETCH;
            end else s_d = s_q + 8'd1;
            ST_FETCH: begin
                // addresses issued on k=0..5, data lands on k=1..6
                if (k_q != 3'd6) begin
                    buf_adr_o = ofs[6:0];
                    oob_d     = (ofs >= len_q);
                end
                if (k_q != 3'd0) byte_d[k_q - 3'd1] = oob_q ? 8'h00 : buf_dat_i;
                if (k_q == 3'd6) begin
                    k_d     = 3'd0;
                    state_d = ST_WR_IDX;
                end else k_d = k_q + 3'd1;
            end
            ST_WR_IDX: if (x_done) state_d = ST_WR_W1;
            ST_WR_W1:  if (x_done) state_d = ST_WR_W2;
            ST_WR_W2:  if (x_done) state_d = ST_WR_W3;
`ifdef MAC_SETUP_VERIFY_EN
            ST_WR_W3:  if (x_done) begin v_d = 2'd0; state_d = ST_VERIFY; end
            ST_VERIFY: if (x_done) begin
                if (x_rdat != exp_w) err_d = 1'b1;
                if (v_q == 2'd2) state_d = ST_NEXT;
                else v_d = v_q + 2'd1;
            end
`else
            ST_WR_W3:  if (x_done) state_d = ST_NEXT;
`endif
            ST_NEXT: if (e_q == 4'(NUM_ENTRIES - 1)) state_d = ST_WR_ZERO;
            else begin
                e_d     = e_q + 4'd1;
                state_d = ST_FETCH;
            end
            ST_WR_ZERO: if (x_done || x_tmo) begin
                stpac_d = 1'b0;
                s_d     = 8'd0;
                state_d = ST_EXIT;
            end
            ST_EXIT: if (s_q == 8'(SETTLE - 1)) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end else s_d = s_q + 8'd1;
            default: state_d = ST_IDLE;
        endcase
        // a missing ack abandons the load but still parks the index at 0
        if (x_tmo) begin
            err_d = 1'b1;
            if (state_q != ST_WR_ZERO) state_d = ST_WR_ZERO;
        end
    end

    always_ff @(posedge wb_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            e_q     <= 4'd0;
            k_q     <= 3'd0;
            s_q     <= 8'd0;
            len_q   <= 8'd0;
            byte_q  <= '0;
            oob_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            stpac_q <= 1'b0;
            pend_q  <= 1'b0;
`ifdef MAC_SETUP_VERIFY_EN
            v_q     <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            k_q     <= k_d;
            s_q     <= s_d;
            len_q   <= len_d;
            byte_q  <= byte_d;
            oob_q   <= oob_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            stpac_q <= stpac_d;
            pend_q  <= pend_d;
`ifdef MAC_SETUP_VERIFY_EN
            v_q     <= v_d;
`endif
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;
    assign pms_o  = {promisc_i, stpac_q};

endmodule

// File: tb/tb_mac_setup_seq.sv
// Bench for mac_setup_seq: setup buffer model plus a filter model with
// 2-cycle ack and a 14x48 address table.
module tb_mac_setup_seq;
    localparam int ACK_TMO = 16;
    localparam logic [47:0] SENT = 48'hDEAD_BEEF_0BAD;

    logic       wb_clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       promisc_i = 1'b0;
    logic [7:0] len_i = 8'd0;
    logic       busy_o, done_o, err_o;
    logic [6:0] buf_adr_o;
    logic [7:0] buf_dat_i;
    logic [1:0] pms_o;

    mac_setup_if bus ();

    mac_setup_seq #(.ACK_TMO(ACK_TMO), .SETTLE(2)) dut (
        .wb_clk_i  (wb_clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .len_i     (len_i),
        .promisc_i (promisc_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .buf_adr_o (buf_adr_o),
        .buf_dat_i (buf_dat_i),
        .m         (bus),
        .pms_o     (pms_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    logic [7:0] bmem [0:127];
    always @(posedge wb_clk_i) buf_dat_i <= bmem[buf_adr_o];

    // filter model
    logic [47:0] tbl [0:13];
    logic [3:0]  idx_m = 4'd0;
    logic [15:0] last_idx = 16'hFFFF;
    logic [15:0] w;
    int ack_dly = 0, bus_n = 0, cur_n = 0, tmo_len = 0, idx_wr_cnt = 0;
    int sup_at = -1;
    logic cyc_d1 = 1'b0, clr = 1'b0, corrupt = 1'b0;

    always @(posedge wb_clk_i) begin
        cur_n = bus_n + ((bus.m_cyc_o && !cyc_d1) ? 1 : 0);
        bus_n <= cur_n;
        cyc_d1 <= bus.m_cyc_o;
        bus.m_ack_i <= 1'b0;
        if (clr) for (int i = 0; i < 14; i++) tbl[i] <= SENT;
        if (bus.m_cyc_o && bus.m_stb_o) begin
            if (cur_n == sup_at) tmo_len <= tmo_len + 1;
            else if (!bus.m_ack_i) begin
                if (ack_dly == 1) begin
                    ack_dly <= 0;
                    bus.m_ack_i <= 1'b1;
                    if (bus.m_we_o) begin
                        if (bus.m_adr_o == 3'd0) begin
                            idx_m <= bus.m_dat_o[3:0];
                            idx_wr_cnt <= idx_wr_cnt + 1;
                            last_idx <= bus.m_dat_o;
                        end else if (idx_m < 4'd14) begin
                            w = bus.m_dat_o;
                            if (corrupt && idx_m == 4'd4 && bus.m_adr_o == 3'd1) w[0] = ~w[0];
                            case (bus.m_adr_o)
                                3'd1: tbl[idx_m][15:0]  <= w;
                                3'd2: tbl[idx_m][31:16] <= w;
                                3'd3: tbl[idx_m][47:32] <= w;
                                default: ;
                            endcase
                        end
                    end else if (idx_m < 4'd14) begin
                        case (bus.m_adr_o)
                            3'd1: bus.m_dat_i <= tbl[idx_m][15:0];
                            3'd2: bus.m_dat_i <= tbl[idx_m][31:16];
                            3'd3: bus.m_dat_i <= tbl[idx_m][47:32];
                            default: bus.m_dat_i <= 16'd0;
                        endcase
                    end
                end else ack_dly <= ack_dly + 1;
            end
        end else ack_dly <= 0;
    end

    int done_cnt = 0, we_lo = 0, proto_bad = 0;
    always @(posedge wb_clk_i) if (done_o) done_cnt++;
    always @(negedge wb_clk_i) begin
        if (bus.m_cyc_o && !bus.m_we_o) we_lo++;
        if (bus.m_stb_o !== bus.m_cyc_o || bus.m_sel_o !== 2'b11) proto_bad++;
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_buf(input int mode);
        int o;
        for (int a = 0; a < 128; a++) bmem[a] = (mode == 0) ? 8'h5A : 8'h00;
        if (mode == 0) begin
            for (int e = 0; e < 14; e++)
                for (int k = 0; k < 6; k++) begin
                    o = ((e < 7) ? 0 : 64) + k * 8 + (e % 7) + 1;
                    bmem[o] = (k == 0) ? 8'h02 : (k == 5) ? 8'(e) : 8'h00;
                end
        end else begin
            bmem[1] = 8'hAA; bmem[9] = 8'hBB; bmem[17] = 8'hCC;
            bmem[25] = 8'hDD; bmem[33] = 8'hEE; bmem[41] = 8'hFF;
            bmem[71] = 8'h11;
        end
    endtask

    task automatic clr_tbl();
        clr = 1'b1;
        @(negedge wb_clk_i);
        clr = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 5000) begin
            @(negedge wb_clk_i);
            n++;
        end
        check("busy_drop_bound", {63'd0, busy_o}, 64'd0);
        repeat (4) @(negedge wb_clk_i);
    endtask

    task automatic pulse_start(input logic [7:0] len);
        len_i = len;
        start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
    endtask

    task automatic run_load(input logic [7:0] len, output int nd, output int ni);
        int d0, i0;
        d0 = done_cnt;
        i0 = idx_wr_cnt;
        pulse_start(len);
        wait_idle();
        nd = done_cnt - d0;
        ni = idx_wr_cnt - i0;
    endtask

    task automatic wait_idx(input int i0, input int n);
        int c = 0;
        while (!(idx_wr_cnt - i0 >= n && bus.m_cyc_o) && c < 3000) begin
            @(negedge wb_clk_i);
            c++;
        end
        check("idx_wait_bound", 64'(c < 3000), 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctl"}, {57'd0, busy_o, done_o, err_o, bus.m_cyc_o, bus.m_stb_o, bus.m_we_o, pms_o[0]}, 64'd0);
        check({tag, "_adr_dat"}, {41'd0, bus.m_adr_o, bus.m_dat_o, buf_adr_o}, 64'd0);
    endtask

    typedef struct {
        logic [7:0]  len;
        int          mode;
        int          e;
        logic [47:0] exp;
    } vec_t;

    initial begin
        vec_t vecs [14];
        int nd, ni, d0, i0;
        vecs = '{
            '{8'd128, 0, 0,  48'h000000000002},
            '{8'd128, 0, 6,  48'h060000000002},
            '{8'd128, 0, 7,  48'h070000000002},
            '{8'd128, 0, 13, 48'h0d0000000002},
            '{8'd64,  0, 6,  48'h060000000002},
            '{8'd64,  0, 7,  48'h000000000000},
            '{8'd64,  0, 13, 48'h000000000000},
            '{8'd111, 0, 12, 48'h0c0000000002},
            '{8'd111, 0, 13, 48'h000000000002},
            '{8'd200, 0, 13, 48'h0d0000000002},
            '{8'd0,   0, 5,  48'h000000000000},
            '{8'd128, 1, 0,  48'hFFEEDDCCBBAA},
            '{8'd128, 1, 13, 48'h000000000011},
            '{8'd128, 1, 1,  48'h000000000000}
        };

        repeat (3) @(negedge wb_clk_i);
        check_reset_vals("reset");
        rst_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        check("idle_busy", {63'd0, busy_o}, 64'd0);

        for (int i = 0; i < 14; i++) begin
            fill_buf(vecs[i].mode);
            clr_tbl();
            run_load(vecs[i].len, nd, ni);
            check($sformatf("tbl_len%0d_m%0d_e%0d", vecs[i].len, vecs[i].mode, vecs[i].e),
                  {16'd0, tbl[vecs[i].e]}, {16'd0, vecs[i].exp});
            check($sformatf("done_once_v%0d", i), 64'(nd), 64'd1);
            check($sformatf("err_v%0d", i), {63'd0, err_o}, 64'd0);
            check($sformatf("idx_writes_v%0d", i), 64'(ni), 64'd15);
            check($sformatf("final_idx_v%0d", i), {48'd0, last_idx}, 64'd0);
            check($sformatf("stpac_off_v%0d", i), {63'd0, pms_o[0]}, 64'd0);
        end

        // ack withheld on the 3rd bus cycle (entry 0, W2)
        promisc_i = 1'b1;
        fill_buf(0);
        clr_tbl();
        sup_at = bus_n + 3;
        run_load(8'd128, nd, ni);
        check("tmo_err", {63'd0, err_o}, 64'd1);
        check("tmo_pms", {62'd0, pms_o}, 64'd2);
        check("tmo_busy", {63'd0, busy_o}, 64'd0);
        check("tmo_done", 64'(nd), 64'd1);
        check("tmo_cyc_len", 64'(tmo_len), 64'(ACK_TMO));
        check("tmo_idx_writes", 64'(ni), 64'd2);
        check("tmo_final_idx", {48'd0, last_idx}, 64'd0);
        check("tmo_skip_e1", {16'd0, tbl[1]}, {16'd0, SENT});
        promisc_i = 1'b0;

        // next start clears the sticky error
        pulse_start(8'd128);
        check("err_clear", {62'd0, err_o, busy_o}, 64'd1);
        wait_idle();
        check("err_clear_end", {63'd0, err_o}, 64'd0);

        // start re-pulsed mid-load is ignored
        clr_tbl();
        d0 = done_cnt;
        i0 = idx_wr_cnt;
        pulse_start(8'd128);
        wait_idx(i0, 3);
        pulse_start(8'd20);
        wait_idle();
        check("restart_done", 64'(done_cnt - d0), 64'd1);
        check("restart_idx_writes", 64'(idx_wr_cnt - i0), 64'd15);
        check("restart_tbl13", {16'd0, tbl[13]}, 64'h0000_0d0000000002);

        // start coinciding with done_o is ignored
        d0 = done_cnt;
        pulse_start(8'd128);
        begin
            int c = 0;
            while (!done_o && c < 5000) begin
                @(negedge wb_clk_i);
                c++;
            end
            check("done_wait_bound", {63'd0, done_o}, 64'd1);
        end
        start_i = 1'b1;
        @(negedge wb_clk_i);
        start_i = 1'b0;
        check("start_on_done", {63'd0, busy_o}, 64'd0);
        repeat (20) @(negedge wb_clk_i);
        check("start_on_done_cnt", 64'(done_cnt - d0), 64'd1);

        // async reset during entry 5
        d0 = done_cnt;
        i0 = idx_wr_cnt;
        pulse_start(8'd128);
        wait_idx(i0, 6);
        #2 rst_i = 1'b1;
        #1;
        check("rst_bus_release", {61'd0, bus.m_cyc_o, pms_o[0], busy_o}, 64'd0);
        repeat (2) @(negedge wb_clk_i);
        rst_i = 1'b0;
        repeat (60) @(negedge wb_clk_i);
        check("rst_no_done", 64'(done_cnt - d0), 64'd0);
        check_reset_vals("post_rst");

`ifdef MAC_SETUP_VERIFY_EN
        fill_buf(0);
        clr_tbl();
        corrupt = 1'b1;
        run_load(8'd128, nd, ni);
        corrupt = 1'b0;
        check("vfy_err", {63'd0, err_o}, 64'd1);
        check("vfy_idx_writes", 64'(ni), 64'd15);
        check("vfy_tbl4", {16'd0, tbl[4]}, 64'h0000_040000000003);
        check("vfy_tbl13", {16'd0, tbl[13]}, 64'h0000_0d0000000002);
`else
        check("we_with_cyc", 64'(we_lo), 64'd0);
`endif
        check("stb_sel_proto", 64'(proto_bad), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
